// File: rtl/data_a_pkg.sv
// Shared types and constants for the data_a input-conditioning path.
//   debounce_state_t : debounce FSM states (levels idle / checking a change)
//   DEBOUNCE_DEFAULT : default number of stable samples needed to commit a level
package data_a_pkg;

    typedef enum logic [1:0] {
        IDLE_LO  = 2'd0,
        CHECK_HI = 2'd1,
        IDLE_HI  = 2'd2,
        CHECK_LO = 2'd3
    } debounce_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/data_a_sync.sv
// Multi-flop synchroniser for an asynchronous level into the i_clk domain.
// Plain shift chain with nothing between stages, so any async input of the
// consumer can reuse it.
//   i_clk   : destination clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears every stage
//   i_d     : asynchronous input level
//   o_q     : synchronised level (last stage)
module data_a_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_d};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/data_a_debounce.sv
// Front-end conditioner for the consumer's i_data_a input: synchronises a raw
// async level, debounces it with a stability counter and emits a clean level
// plus single-cycle rise / fall / glitch pulses.
//   i_clk      : system clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_en       : debounce enable; low holds o_data_a and drops any pending check
//   i_data_raw : asynchronous raw level
//   o_data_a   : debounced level (registered)
//   o_rise     : one-cycle pulse on a committed 0->1
//   o_fall     : one-cycle pulse on a committed 1->0
//   o_glitch   : one-cycle pulse when a pending change is abandoned
module data_a_debounce
    import data_a_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_data_raw,
    output logic o_data_a,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic s;

    debounce_state_t      state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 data_q, data_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 glitch_q, glitch_d;

    data_a_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_data_raw),
        .o_q    (s)
    );

    // The IDLE edge that first sees the new level counts as sample 1, so a
    // commit happens when the CHECK state sees its (DEBOUNCE_CYCLES)th sample.
    // A commit always lands in IDLE, which keeps pulses from ever being
    // back-to-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (i_en && s) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHECK_HI: begin
                if (!i_en) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (!s) begin
                    state_d  = IDLE_LO;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    data_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (i_en && !s) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHECK_LO: begin
                if (!i_en) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (s) begin
                    state_d  = IDLE_HI;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                data_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            data_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign o_data_a = data_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign o_glitch = glitch_q;

endmodule

// File: tb/tb_data_a_debounce.sv
// Bench for data_a_debounce: three instances (DEBOUNCE_CYCLES 16, 4, 2) share
// one stimulus stream. A run-length reference model predicts every output
// each cycle into a queue; a negedge monitor pops and compares. Directed
// phases add latency, enable, reset and toggle checks.
module tb_data_a_debounce;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       raw   = 1'b0;
    logic [2:0] d_a, rise, fall, gl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int dc(int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    data_a_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_d16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data_raw(raw),
        .o_data_a(d_a[0]), .o_rise(rise[0]), .o_fall(fall[0]), .o_glitch(gl[0]));
    data_a_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data_raw(raw),
        .o_data_a(d_a[1]), .o_rise(rise[1]), .o_fall(fall[1]), .o_glitch(gl[1]));
    data_a_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data_raw(raw),
        .o_data_a(d_a[2]), .o_rise(rise[2]), .o_fall(fall[2]), .o_glitch(gl[2]));

    // ---------------- reference model ----------------
    // The level seen by the debouncer at an edge is the raw level sampled two
    // edges earlier. A level commits once it has differed from the current
    // level for D consecutive enabled samples; an interrupted run is a glitch.
    logic        hist[$] = '{1'b0, 1'b0};
    logic        m_lvl[3] = '{default: 1'b0};
    int          m_run[3] = '{default: 0};
    int          m_g2 = 0;
    logic [11:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        logic        s;
        logic        r, f, g;
        logic [11:0] e;
        if (!rst_n) begin
            hist = '{1'b0, 1'b0};
            for (int k = 0; k < 3; k++) begin
                m_lvl[k] = 1'b0;
                m_run[k] = 0;
            end
            exp_q.delete();
        end else begin
            s = hist.pop_front();
            hist.push_back(raw);
            e = '0;
            for (int k = 0; k < 3; k++) begin
                r = 1'b0; f = 1'b0; g = 1'b0;
                if (!en) begin
                    m_run[k] = 0;
                end else if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == dc(k)) begin
                        m_lvl[k] = s;
                        r = s;
                        f = !s;
                        m_run[k] = 0;
                    end
                end else if (m_run[k] > 0) begin
                    g = 1'b1;
                    m_run[k] = 0;
                    if (k == 2) m_g2++;
                end
                e[k*4 +: 4] = {g, f, r, m_lvl[k]};
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    logic [2:0] prev_p[3] = '{default: 3'b0};
    int         viol      = 0;
    int         dut_g2    = 0;
    int         d2_chg    = 0;
    logic       d2_prev   = 1'b0;

    always @(negedge clk) begin
        logic [11:0] e;
        logic [3:0]  act;
        logic [2:0]  p;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                act = {gl[k], fall[k], rise[k], d_a[k]};
                n_chk++;
                if (act !== e[k*4 +: 4]) begin
                    n_fail++;
                    $display("FAIL model_cmp dut%0d {glitch,fall,rise,data}: got %b expected %b at %0t",
                             k, act, e[k*4 +: 4], $time);
                end
            end
        end
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                p = {gl[k], fall[k], rise[k]};
                if ($countones(p) > 1 || (p != 3'b0 && prev_p[k] != 3'b0)) viol++;
                prev_p[k] = p;
            end
            if (gl[2]) dut_g2++;
            if (d_a[2] !== d2_prev) d2_chg++;
            d2_prev = d_a[2];
        end else begin
            for (int k = 0; k < 3; k++) prev_p[k] = 3'b0;
            d2_prev = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after a falling edge, far from the sampling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Count rising edges until DUT0's level equals lvl (0 = never, bounded).
    task automatic measure(input logic lvl, output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (d_a[0] === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    // Observe DUT k for n cycles, summing its pulses and cycles at level 1.
    task automatic observe(input int n, input int k,
                           output int nr, output int nf, output int ng, output int nhi);
        nr = 0; nf = 0; ng = 0; nhi = 0;
        repeat (n) begin
            cyc(1);
            nr  += int'(rise[k]);
            nf  += int'(fall[k]);
            ng  += int'(gl[k]);
            nhi += int'(d_a[k]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, nr, nf, ng, nhi, nr2, nf2, ng2, nhi2;
        int g_dut0, g_mdl0, c0;

        // reset state
        cyc(3);
        chk("reset data_a", int'(d_a), 0);
        chk("reset pulses", int'({rise, fall, gl}), 0);

        // raw held low: nothing ever happens
        rst_n = 1'b1;
        en    = 1'b1;
        observe(50, 0, nr, nf, ng, nhi);
        chk("low hold pulses", nr + nf + ng, 0);
        chk("low hold level", nhi, 0);

        // 0->1 latency at default parameters
        raw = 1'b1;
        measure(1'b1, n);
        chk("rise latency edges", n, 18);
        chk("rise pulse at commit", int'(rise[0]), 1);
        chk("no fall/glitch at commit", int'({fall[0], gl[0]}), 0);
        @(posedge clk);
        #1;
        chk("rise pulse cleared", int'(rise[0]), 0);

        // back low, then a 3-sample pulse glitches the D=4 instance
        raw = 1'b0;
        cyc(30);
        raw = 1'b1;
        observe(3, 1, nr, nf, ng, nhi);
        raw = 1'b0;
        observe(10, 1, nr2, nf2, ng2, nhi2);
        chk("d4 short pulse glitches", ng + ng2, 1);
        chk("d4 short pulse no rise", nr + nr2, 0);
        chk("d4 short pulse level", nhi + nhi2, 0);
        raw = 1'b1;
        observe(4, 1, nr, nf, ng, nhi);
        raw = 1'b0;
        observe(3, 1, nr2, nf2, ng2, nhi2);
        chk("d4 four-sample rise", nr + nr2, 1);

        // enable dropped mid-check holds the level without a glitch
        raw = 1'b1;
        cyc(30);
        raw = 1'b0;
        cyc(8);
        en  = 1'b0;
        observe(10, 0, nr, nf, ng, nhi);
        chk("en low no glitch", ng + nf, 0);
        chk("en low holds level", nhi, 10);
        en = 1'b1;
        measure(1'b0, n);
        chk("fall after enable edges", n, 16);
        chk("fall pulse at commit", int'(fall[0]), 1);
        cyc(1);

        // asynchronous reset mid-check with the level high
        raw = 1'b1;
        cyc(30);
        raw = 1'b0;
        cyc(5);
        #1;
        rst_n = 1'b0;
        raw   = 1'b1;
        #1;
        chk("async reset clears level", int'(d_a), 0);
        chk("async reset clears pulses", int'({rise, fall, gl}), 0);
        cyc(2);
        rst_n = 1'b1;
        measure(1'b1, n);
        chk("rise latency after reset", n, 18);
        cyc(30);

        // toggling every cycle never satisfies D=2
        c0     = d2_chg;
        g_dut0 = dut_g2;
        g_mdl0 = m_g2;
        for (int i = 0; i < 200; i++) begin
            raw = ~raw;
            cyc(1);
        end
        cyc(4);
        chk("d2 toggle level changes", d2_chg - c0, 0);
        chk("d2 toggle glitch count", dut_g2 - g_dut0, m_g2 - g_mdl0);

        // random holds and enables, model-checked every cycle
        for (int i = 0; i < 250; i++) begin
            raw = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) cyc($urandom_range(14, 24));
            else                           cyc($urandom_range(1, 6));
        end
        en = 1'b1;
        cyc(25);

        chk("pulse exclusivity violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/data_a_debounce.md
Name: data_a_debounce

Overview:
- Front-end conditioning stage that drives the `i_data_a` input of the downstream consumer stage.
- Synchronises an asynchronous raw level into the `i_clk` domain and debounces it with a stability counter.
- Produces a clean level plus single-cycle rise/fall/glitch pulses.
- Sits directly upstream of the consumer: `o_data_a` connects straight to its `i_data_a`, sharing `i_clk` and `i_rst_n`.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal ≥ 2).
- DEBOUNCE_CYCLES, 16, consecutive synchronised samples of the new level required to commit it (legal ≥ 2).
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), stability counter width (derived; not overridden).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_en  input  1  debounce enable; low freezes output and clears the check.
- i_data_raw  input  1  asynchronous raw level (pad or other domain).
- o_data_a  output  1  debounced level, registered.
- o_rise  output  1  one-cycle pulse when o_data_a commits 0→1.
- o_fall  output  1  one-cycle pulse when o_data_a commits 1→0.
- o_glitch  output  1  one-cycle pulse when a pending change is abandoned.

Behaviour:
- Clock/reset: one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- Reset values: all synchroniser flops 0; state IDLE_LO; counter 0; o_data_a, o_rise, o_fall, o_glitch all 0.
- Synchroniser: a shift chain of SYNC_STAGES flops. `s` = last stage. No logic between stages.
- FSM states: IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO.
- IDLE_LO:
  - if i_en and s==1 → CHECK_HI, cnt←1.
  - else stay, cnt←0.
- CHECK_HI:
  - if !i_en → IDLE_LO, cnt←0, no pulse.
  - else if s==0 → IDLE_LO, cnt←0, o_glitch←1.
  - else if cnt==DEBOUNCE_CYCLES-1 → IDLE_HI, cnt←0, o_data_a←1, o_rise←1.
  - else cnt←cnt+1.
- IDLE_HI / CHECK_LO: mirror of the above with levels inverted; commit sets o_data_a←0 and o_fall←1.
- Latency: if the raw level is held, o_data_a changes on edge R+SYNC_STAGES-1+DEBOUNCE_CYCLES, where R is the first edge capturing the new raw value (defaults: R+17). Pulses assert on that same edge and clear the next edge.
- Stability requirement: s must equal the new level for DEBOUNCE_CYCLES consecutive sampling edges. Any opposing sample aborts, and the count restarts from scratch on the next change.
- Pulse exclusivity: o_rise, o_fall and o_glitch are mutually exclusive and never asserted on consecutive cycles. After a commit the FSM must pass through IDLE for at least one cycle.
- Enable:
  - i_en low holds o_data_a and clears any check without a glitch pulse.
  - Synchroniser keeps running while i_en is low.
  - On i_en rising with s≠o_data_a, a check starts on the next edge.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset mid-check: all state is cleared immediately (asynchronous). After release, o_data_a=0 even if the raw level is 1; a high raw level then commits after the full latency.
- Simultaneous i_en low with commit condition: enable wins; no commit, no pulse.
- Unreachable state encodings recover to IDLE_LO.

Decomposition:
- Shared package `data_a_pkg`:
  - enum `debounce_state_t` {IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO}.
  - constant `DEBOUNCE_DEFAULT` = 16.
- One sub-module `data_a_sync`:
  - parameter SYNC_STAGES.
  - ports i_clk, i_rst_n, i_d, o_q.
  - Reusable for other asynchronous inputs feeding the same consumer.
- FSM, counter and pulse registers stay in the top module.

Test Plan:
- Reset then i_en=1, raw held 0 for 50 cycles → o_data_a=0, no pulses ever.
- Defaults, raw 0→1 captured at edge 10 and held → o_data_a=1 and o_rise=1 exactly at edge 27; o_rise=0 at edge 28; o_fall/o_glitch stay 0.
- DEBOUNCE_CYCLES=4, raw high for 3 cycles then low → o_glitch single pulse, o_data_a stays 0; a following 4-cycle-stable high commits with o_rise.
- From o_data_a=1, drop i_en mid-CHECK_LO → o_data_a stays 1, no o_glitch; raise i_en with raw still 0 → o_fall after DEBOUNCE_CYCLES further edges.
- Assert i_rst_n=0 asynchronously mid-check with o_data_a=1 → o_data_a=0 immediately, no clock needed; raw held 1 after release → o_rise at edge release+SYNC_STAGES-1+DEBOUNCE_CYCLES.
- Raw toggling every cycle for 200 cycles with DEBOUNCE_CYCLES=2 → o_data_a never changes; the glitch count is checked against a reference model.
